seq_multiplier_param: RTL

- Parametrised sequential shift-add multiplier. Next generation of the team's 8x8 start/ready multiplier.
- Adds a configurable operand width, a per-operation signed/unsigned mode, and a busy flag.
- Adds defined restart and ignore rules for start.
- Sits in the datapath as a multi-cycle arithmetic unit driven by a controller through a start/ready handshake.

---
 rtl/mult_pkg.sv | 38 +++
 rtl/mult_datapath.sv | 81 ++++++++
 rtl/seq_multiplier_param.sv | 109 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned MAX_W   = 32;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    // Counter must hold the value WIDTH after the last iteration.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Magnitude of a w-bit operand when signed, raw value otherwise; -2^(w-1) maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] mag_cond(input logic [MAX_W-1:0] v,
                                                  input int unsigned       w,
                                                  input logic              sgn);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] res;
        if (w >= MAX_W) begin
            mask = {MAX_W{1'b1}};
        end else begin
            mask = (MAX_W'(1) << w) - MAX_W'(1);
        end
        if (sgn && v[w-1]) begin
            res = (~v + MAX_W'(1)) & mask;
        end else begin
            res = v & mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand magnitudes, {acc, mplier} product register, add/shift step and final sign fix-up.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               finish_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   v1_i,
    input  logic [WIDTH-1:0]   v2_i,
    output logic [2*WIDTH-1:0] out_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mcand_d;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mplier_d;
    logic               neg_q;
    logic               neg_d;
    logic [2*WIDTH-1:0] out_q;
    logic [2*WIDTH-1:0] out_d;

    logic [MAX_W-1:0]   mag1_s;
    logic [MAX_W-1:0]   mag2_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;

    assign mag1_s = mag_cond(MAX_W'(v1_i), WIDTH, signed_mode_i);
    assign mag2_s = mag_cond(MAX_W'(v2_i), WIDTH, signed_mode_i);
    assign sum_s  = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    // After WIDTH iterations acc[WIDTH] is always zero, so the low 2*WIDTH bits are the product.
    assign prod_s = {acc_q[WIDTH-1:0], mplier_q};

    // Next-state for operand latch, add/shift iteration and signed result write.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        out_d    = out_q;
        if (load_i) begin
            mcand_d  = mag1_s[WIDTH-1:0];
            mplier_d = mag2_s[WIDTH-1:0];
            acc_d    = '0;
            neg_d    = signed_mode_i & (v1_i[WIDTH-1] ^ v2_i[WIDTH-1]);
        end else if (step_i) begin
            acc_d    = {1'b0, sum_s[WIDTH:1]};
            mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        end else if (finish_i) begin
            out_d = neg_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
        end else begin
            out_d = out_q;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/seq_multiplier_param.sv
// Start/ready sequential multiplier: FSM and iteration counter driving mult_datapath.
module seq_multiplier_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   v1,
    input  logic [WIDTH-1:0]   v2,
    output logic [2*WIDTH-1:0] out,
    output logic               ready,
    output logic               busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    mult_state_e      state_q;
    mult_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ready_q;
    logic             ready_d;
    logic             busy_q;
    logic             busy_d;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    // Next-state, counter and strobe generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = CALC;
                end else begin
                    state_d = state_q;
                end
            end
            CALC: begin
                step_s = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SIGN;
                end else begin
                    state_d = CALC;
                end
            end
            SIGN: begin
                finish_s = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_s),
        .step_i       (step_s),
        .finish_i     (finish_s),
        .signed_mode_i(signed_mode),
        .v1_i         (v1),
        .v2_i         (v2),
        .out_o        (out)
    );

    assign ready = ready_q;
    assign busy  = busy_q;

endmodule
